// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cache_mem_arbiter
//  Purpose  : Shares one AXI-style memory port between the icache (reads) and
//             the dcache (reads and write-backs). Reads and the single-entry
//             write buffer run as two independent FSMs. A read to a line that
//             is held in the write buffer is stalled until the write completes.
//  Options  : CACHE_ARB_RR_EN - round-robin between icache and dcache on a
//             simultaneous read request (default: fixed dcache priority).
//  Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int LINE_OFF_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    // icache miss interface
    input  logic                  ic_rd_req,
    input  logic [2:0]            ic_rd_type,
    input  logic [ADDR_WIDTH-1:0] ic_rd_addr,
    output logic                  ic_rd_rdy,
    output logic                  ic_ret_valid,
    output logic                  ic_ret_last,
    output logic [31:0]           ic_ret_data,
    // dcache miss interface
    input  logic                  dc_rd_req,
    input  logic [2:0]            dc_rd_type,
    input  logic [ADDR_WIDTH-1:0] dc_rd_addr,
    output logic                  dc_rd_rdy,
    output logic                  dc_ret_valid,
    output logic                  dc_ret_last,
    output logic [31:0]           dc_ret_data,
    input  logic                  dc_wr_req,
    input  logic [2:0]            dc_wr_type,
    input  logic [ADDR_WIDTH-1:0] dc_wr_addr,
    input  logic [3:0]            dc_wr_wstrb,
    input  logic [127:0]          dc_wr_data,
    output logic                  dc_wr_rdy,
    // memory read address / data
    output logic                  mem_ar_valid,
    input  logic                  mem_ar_ready,
    output logic [ADDR_WIDTH-1:0] mem_ar_addr,
    output logic [7:0]            mem_ar_len,
    output logic [2:0]            mem_ar_size,
    input  logic                  mem_r_valid,
    output logic                  mem_r_ready,
    input  logic [31:0]           mem_r_data,
    input  logic                  mem_r_last,
    // memory write address / data / response
    output logic                  mem_aw_valid,
    input  logic                  mem_aw_ready,
    output logic [ADDR_WIDTH-1:0] mem_aw_addr,
    output logic [7:0]            mem_aw_len,
    output logic [2:0]            mem_aw_size,
    output logic                  mem_w_valid,
    input  logic                  mem_w_ready,
    output logic [31:0]           mem_w_data,
    output logic [3:0]            mem_w_strb,
    output logic                  mem_w_last,
    input  logic                  mem_b_valid,
    output logic                  mem_b_ready
);

    localparam logic [2:0] c_TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    // Read side state
    rd_state_t             rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [2:0]            rd_type_q, rd_type_d;
    logic                  rd_owner_dc_q, rd_owner_dc_d;

    // Write buffer state
    wr_state_t             wr_state_q, wr_state_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [2:0]            wb_type_q, wb_type_d;
    logic [3:0]            wb_strb_q, wb_strb_d;
    logic [127:0]          wb_data_q, wb_data_d;
    logic [1:0]            beat_cnt_q, beat_cnt_d;

`ifdef CACHE_ARB_RR_EN
    // High when the dcache received the most recent read grant
    logic                  last_grant_q, last_grant_d;
`endif

    logic w_wr_accept;
    logic w_ic_haz, w_dc_haz;
    logic w_ic_elig, w_dc_elig;
    logic w_grant_ic, w_grant_dc;
    logic w_rd_line, w_wb_line;
    logic w_w_last;

    function automatic logic same_line(input logic [ADDR_WIDTH-1:0] a,
                                       input logic [ADDR_WIDTH-1:0] b);
        return a[ADDR_WIDTH-1:LINE_OFF_BITS] == b[ADDR_WIDTH-1:LINE_OFF_BITS];
    endfunction

    // Hazard detection against the buffered (or just-accepted) write line, then arbitration
    always_comb begin
        w_wr_accept = dc_wr_req && (wr_state_q == W_IDLE);
        w_ic_haz    = (wb_valid_q && same_line(wb_addr_q, ic_rd_addr)) ||
                      (w_wr_accept && same_line(dc_wr_addr, ic_rd_addr));
        w_dc_haz    = (wb_valid_q && same_line(wb_addr_q, dc_rd_addr)) ||
                      (w_wr_accept && same_line(dc_wr_addr, dc_rd_addr));
        w_ic_elig   = (rd_state_q == R_IDLE) && ic_rd_req && !w_ic_haz;
        w_dc_elig   = (rd_state_q == R_IDLE) && dc_rd_req && !w_dc_haz;
`ifdef CACHE_ARB_RR_EN
        w_grant_dc  = w_dc_elig && (!w_ic_elig || !last_grant_q);
`else
        w_grant_dc  = w_dc_elig;
`endif
        w_grant_ic  = w_ic_elig && !w_grant_dc;
        w_rd_line   = (rd_type_q == c_TYPE_LINE);
        w_wb_line   = (wb_type_q == c_TYPE_LINE);
        w_w_last    = (beat_cnt_q == (w_wb_line ? 2'd3 : 2'd0));
    end

    // Read FSM next state: accept in idle, address phase, data phase until last beat
    always_comb begin
        rd_state_d    = rd_state_q;
        rd_addr_d     = rd_addr_q;
        rd_type_d     = rd_type_q;
        rd_owner_dc_d = rd_owner_dc_q;
`ifdef CACHE_ARB_RR_EN
        last_grant_d  = last_grant_q;
`endif
        case (rd_state_q)
            R_IDLE: begin
                if (w_grant_dc) begin
                    rd_state_d    = R_AR;
                    rd_addr_d     = dc_rd_addr;
                    rd_type_d     = dc_rd_type;
                    rd_owner_dc_d = 1'b1;
`ifdef CACHE_ARB_RR_EN
                    last_grant_d  = 1'b1;
`endif
                end else if (w_grant_ic) begin
                    rd_state_d    = R_AR;
                    rd_addr_d     = ic_rd_addr;
                    rd_type_d     = ic_rd_type;
                    rd_owner_dc_d = 1'b0;
`ifdef CACHE_ARB_RR_EN
                    last_grant_d  = 1'b0;
`endif
                end
            end
            R_AR: begin
                if (mem_ar_ready) rd_state_d = R_DATA;
            end
            R_DATA: begin
                if (mem_r_valid && mem_r_last) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write FSM next state: buffer the request, then AW, W beats, and B response
    always_comb begin
        wr_state_d = wr_state_q;
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_type_d  = wb_type_q;
        wb_strb_d  = wb_strb_q;
        wb_data_d  = wb_data_q;
        beat_cnt_d = beat_cnt_q;
        case (wr_state_q)
            W_IDLE: begin
                if (dc_wr_req) begin
                    wr_state_d = W_AW;
                    wb_valid_d = 1'b1;
                    wb_addr_d  = dc_wr_addr;
                    wb_type_d  = dc_wr_type;
                    wb_strb_d  = dc_wr_wstrb;
                    wb_data_d  = dc_wr_data;
                end
            end
            W_AW: begin
                if (mem_aw_ready) begin
                    wr_state_d = W_DATA;
                    beat_cnt_d = 2'd0;
                end
            end
            W_DATA: begin
                if (mem_w_ready) begin
                    if (w_w_last) wr_state_d = W_RESP;
                    else          beat_cnt_d = beat_cnt_q + 2'd1;
                end
            end
            W_RESP: begin
                if (mem_b_valid) begin
                    wr_state_d = W_IDLE;
                    wb_valid_d = 1'b0;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q    <= R_IDLE;
            rd_addr_q     <= '0;
            rd_type_q     <= '0;
            rd_owner_dc_q <= 1'b0;
            wr_state_q    <= W_IDLE;
            wb_valid_q    <= 1'b0;
            wb_addr_q     <= '0;
            wb_type_q     <= '0;
            wb_strb_q     <= '0;
            wb_data_q     <= '0;
            beat_cnt_q    <= '0;
`ifdef CACHE_ARB_RR_EN
            last_grant_q  <= 1'b0;
`endif
        end else begin
            rd_state_q    <= rd_state_d;
            rd_addr_q     <= rd_addr_d;
            rd_type_q     <= rd_type_d;
            rd_owner_dc_q <= rd_owner_dc_d;
            wr_state_q    <= wr_state_d;
            wb_valid_q    <= wb_valid_d;
            wb_addr_q     <= wb_addr_d;
            wb_type_q     <= wb_type_d;
            wb_strb_q     <= wb_strb_d;
            wb_data_q     <= wb_data_d;
            beat_cnt_q    <= beat_cnt_d;
`ifdef CACHE_ARB_RR_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

    // Output decode from state; every output is held low while reset is high
    always_comb begin
        ic_rd_rdy    = 1'b0;
        ic_ret_valid = 1'b0;
        ic_ret_last  = 1'b0;
        ic_ret_data  = '0;
        dc_rd_rdy    = 1'b0;
        dc_ret_valid = 1'b0;
        dc_ret_last  = 1'b0;
        dc_ret_data  = '0;
        dc_wr_rdy    = 1'b0;
        mem_ar_valid = 1'b0;
        mem_ar_addr  = '0;
        mem_ar_len   = '0;
        mem_ar_size  = '0;
        mem_r_ready  = 1'b0;
        mem_aw_valid = 1'b0;
        mem_aw_addr  = '0;
        mem_aw_len   = '0;
        mem_aw_size  = '0;
        mem_w_valid  = 1'b0;
        mem_w_data   = '0;
        mem_w_strb   = '0;
        mem_w_last   = 1'b0;
        mem_b_ready  = 1'b0;
        if (!reset) begin
            ic_rd_rdy = w_grant_ic;
            dc_rd_rdy = w_grant_dc;
            dc_wr_rdy = (wr_state_q == W_IDLE);
            if (rd_state_q == R_AR) begin
                mem_ar_valid = 1'b1;
                mem_ar_addr  = rd_addr_q;
                mem_ar_len   = w_rd_line ? 8'd3 : 8'd0;
                mem_ar_size  = w_rd_line ? 3'd2 : {1'b0, rd_type_q[1:0]};
            end
            if (rd_state_q == R_DATA) begin
                mem_r_ready = 1'b1;
                if (rd_owner_dc_q) begin
                    dc_ret_valid = mem_r_valid;
                    dc_ret_last  = mem_r_last;
                    dc_ret_data  = mem_r_data;
                end else begin
                    ic_ret_valid = mem_r_valid;
                    ic_ret_last  = mem_r_last;
                    ic_ret_data  = mem_r_data;
                end
            end
            if (wr_state_q == W_AW) begin
                mem_aw_valid = 1'b1;
                mem_aw_addr  = wb_addr_q;
                mem_aw_len   = w_wb_line ? 8'd3 : 8'd0;
                mem_aw_size  = w_wb_line ? 3'd2 : {1'b0, wb_type_q[1:0]};
            end
            if (wr_state_q == W_DATA) begin
                mem_w_valid = 1'b1;
                mem_w_data  = wb_data_q[{beat_cnt_q, 5'd0} +: 32];
                mem_w_strb  = w_wb_line ? 4'hF : wb_strb_q;
                mem_w_last  = w_w_last;
            end
            if (wr_state_q == W_RESP) begin
                mem_b_ready = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_mem_arbiter
//  Purpose  : Directed stimulus for cache_mem_arbiter with a transaction-level
//             reference model compared against the DUT every cycle, plus
//             literal expectations at key points of each scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

    logic         clk;
    logic         reset;
    logic         ic_rd_req, dc_rd_req, dc_wr_req;
    logic [2:0]   ic_rd_type, dc_rd_type, dc_wr_type;
    logic [31:0]  ic_rd_addr, dc_rd_addr, dc_wr_addr;
    logic [3:0]   dc_wr_wstrb;
    logic [127:0] dc_wr_data;
    logic         ic_rd_rdy, ic_ret_valid, ic_ret_last;
    logic [31:0]  ic_ret_data;
    logic         dc_rd_rdy, dc_ret_valid, dc_ret_last;
    logic [31:0]  dc_ret_data;
    logic         dc_wr_rdy;
    logic         mem_ar_valid, mem_ar_ready;
    logic [31:0]  mem_ar_addr;
    logic [7:0]   mem_ar_len;
    logic [2:0]   mem_ar_size;
    logic         mem_r_valid, mem_r_ready, mem_r_last;
    logic [31:0]  mem_r_data;
    logic         mem_aw_valid, mem_aw_ready;
    logic [31:0]  mem_aw_addr;
    logic [7:0]   mem_aw_len;
    logic [2:0]   mem_aw_size;
    logic         mem_w_valid, mem_w_ready, mem_w_last;
    logic [31:0]  mem_w_data;
    logic [3:0]   mem_w_strb;
    logic         mem_b_valid, mem_b_ready;

    int n_chk  = 0;
    int n_pass = 0;

    cache_mem_arbiter #(.ADDR_WIDTH(32), .LINE_OFF_BITS(4)) dut (
        .clk(clk), .reset(reset),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
        .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
        .ic_ret_data(ic_ret_data),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
        .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
        .dc_ret_data(dc_ret_data),
        .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
        .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
        .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready), .mem_ar_addr(mem_ar_addr),
        .mem_ar_len(mem_ar_len), .mem_ar_size(mem_ar_size),
        .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready), .mem_r_data(mem_r_data),
        .mem_r_last(mem_r_last),
        .mem_aw_valid(mem_aw_valid), .mem_aw_ready(mem_aw_ready), .mem_aw_addr(mem_aw_addr),
        .mem_aw_len(mem_aw_len), .mem_aw_size(mem_aw_size),
        .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready), .mem_w_data(mem_w_data),
        .mem_w_strb(mem_w_strb), .mem_w_last(mem_w_last),
        .mem_b_valid(mem_b_valid), .mem_b_ready(mem_b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: one outstanding read record and one write buffer
    // record, advanced by observed handshakes.
    // ------------------------------------------------------------------
    bit         m_rbusy, m_ar_done, m_rown_dc, m_last_dc;
    bit [31:0]  m_raddr;
    bit [2:0]   m_rtype;
    bit         m_wv, m_aw_done;
    bit [31:0]  m_waddr;
    bit [2:0]   m_wtype;
    bit [3:0]   m_wstrb;
    bit [127:0] m_wdata;
    int         m_beats;

    function automatic int nbeats(input bit [2:0] t);
        return (t == 3'b100) ? 4 : 1;
    endfunction

    function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
        return (a / 16) == (b / 16);
    endfunction

    function automatic bit blocked(input logic [31:0] a);
        return (m_wv && same_line(m_waddr, a)) ||
               (!m_wv && dc_wr_req && same_line(dc_wr_addr, a));
    endfunction

    // 0: nobody, 1: icache, 2: dcache
    function automatic int winner();
        bit ice, dce;
        if (m_rbusy) return 0;
        ice = ic_rd_req && !blocked(ic_rd_addr);
        dce = dc_rd_req && !blocked(dc_rd_addr);
`ifdef CACHE_ARB_RR_EN
        if (ice && dce) return m_last_dc ? 1 : 2;
`endif
        if (dce) return 2;
        if (ice) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_rbusy   <= 1'b0;
            m_ar_done <= 1'b0;
            m_last_dc <= 1'b0;
            m_wv      <= 1'b0;
            m_aw_done <= 1'b0;
            m_beats   <= 0;
        end else begin
            if (!m_rbusy) begin
                if (winner() == 2) begin
                    m_rbusy <= 1'b1; m_ar_done <= 1'b0; m_rown_dc <= 1'b1;
                    m_raddr <= dc_rd_addr; m_rtype <= dc_rd_type; m_last_dc <= 1'b1;
                end else if (winner() == 1) begin
                    m_rbusy <= 1'b1; m_ar_done <= 1'b0; m_rown_dc <= 1'b0;
                    m_raddr <= ic_rd_addr; m_rtype <= ic_rd_type; m_last_dc <= 1'b0;
                end
            end else if (!m_ar_done) begin
                if (mem_ar_ready) m_ar_done <= 1'b1;
            end else if (mem_r_valid && mem_r_last) begin
                m_rbusy <= 1'b0;
            end

            if (!m_wv) begin
                if (dc_wr_req) begin
                    m_wv <= 1'b1; m_aw_done <= 1'b0; m_beats <= 0;
                    m_waddr <= dc_wr_addr; m_wtype <= dc_wr_type;
                    m_wstrb <= dc_wr_wstrb; m_wdata <= dc_wr_data;
                end
            end else if (!m_aw_done) begin
                if (mem_aw_ready) m_aw_done <= 1'b1;
            end else if (m_beats < nbeats(m_wtype)) begin
                if (mem_w_ready) m_beats <= m_beats + 1;
            end else if (mem_b_valid) begin
                m_wv <= 1'b0;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    bit        e_rdata_ph, e_wbeat;
    int        e_win, e_nb;
    bit [31:0] e_word;
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_all_zero", {31'd0, |{ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
                dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data, dc_wr_rdy,
                mem_ar_valid, mem_ar_addr, mem_ar_len, mem_ar_size, mem_r_ready,
                mem_aw_valid, mem_aw_addr, mem_aw_len, mem_aw_size,
                mem_w_valid, mem_w_data, mem_w_strb, mem_w_last, mem_b_ready}}, 32'd0);
        end else begin
            e_win = winner();
            chk("m_ic_rd_rdy", ic_rd_rdy, e_win == 1);
            chk("m_dc_rd_rdy", dc_rd_rdy, e_win == 2);
            chk("m_ar_valid", mem_ar_valid, m_rbusy && !m_ar_done);
            if (m_rbusy && !m_ar_done) begin
                chk("m_ar_addr", mem_ar_addr, m_raddr);
                chk("m_ar_len", mem_ar_len, nbeats(m_rtype) - 1);
                chk("m_ar_size", mem_ar_size, (m_rtype == 3'b100) ? 32'd2 : {30'd0, m_rtype[1:0]});
            end
            e_rdata_ph = m_rbusy && m_ar_done;
            chk("m_r_ready", mem_r_ready, e_rdata_ph);
            chk("m_ic_ret_valid", ic_ret_valid, e_rdata_ph && !m_rown_dc && mem_r_valid);
            chk("m_ic_ret_last", ic_ret_last, e_rdata_ph && !m_rown_dc && mem_r_last);
            chk("m_dc_ret_valid", dc_ret_valid, e_rdata_ph && m_rown_dc && mem_r_valid);
            chk("m_dc_ret_last", dc_ret_last, e_rdata_ph && m_rown_dc && mem_r_last);
            if (e_rdata_ph && mem_r_valid)
                chk("m_ret_data", m_rown_dc ? dc_ret_data : ic_ret_data, mem_r_data);

            e_nb = nbeats(m_wtype);
            chk("m_dc_wr_rdy", dc_wr_rdy, !m_wv);
            chk("m_aw_valid", mem_aw_valid, m_wv && !m_aw_done);
            if (m_wv && !m_aw_done) begin
                chk("m_aw_addr", mem_aw_addr, m_waddr);
                chk("m_aw_len", mem_aw_len, e_nb - 1);
                chk("m_aw_size", mem_aw_size, (m_wtype == 3'b100) ? 32'd2 : {30'd0, m_wtype[1:0]});
            end
            e_wbeat = m_wv && m_aw_done && (m_beats < e_nb);
            chk("m_w_valid", mem_w_valid, e_wbeat);
            if (e_wbeat) begin
                e_word = 32'(m_wdata >> (32 * m_beats));
                chk("m_w_data", mem_w_data, e_word);
                chk("m_w_strb", mem_w_strb, (m_wtype == 3'b100) ? 32'hF : {28'd0, m_wstrb});
                chk("m_w_last", mem_w_last, m_beats == e_nb - 1);
            end
            chk("m_b_ready", mem_b_ready, m_wv && m_aw_done && (m_beats == e_nb));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    // Called at the start of an address-phase cycle: accept AR, then stream beats
    task automatic serve_read(input int nb, input logic [31:0] base);
        mem_ar_ready = 1'b1;
        tick();
        mem_ar_ready = 1'b0;
        for (int i = 0; i < nb; i++) begin
            mem_r_valid = 1'b1;
            mem_r_data  = base + i;
            mem_r_last  = (i == nb - 1);
            tick();
        end
        mem_r_valid = 1'b0;
        mem_r_last  = 1'b0;
        mem_r_data  = '0;
    endtask

    initial begin
        reset = 1'b1;
        ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0;
        dc_rd_req = 0; dc_rd_type = 0; dc_rd_addr = 0;
        dc_wr_req = 0; dc_wr_type = 0; dc_wr_addr = 0; dc_wr_wstrb = 0; dc_wr_data = 0;
        mem_ar_ready = 0; mem_r_valid = 0; mem_r_data = 0; mem_r_last = 0;
        mem_aw_ready = 0; mem_w_ready = 0; mem_b_valid = 0;

        // Reset state
        repeat (3) tick();
        look(); chk("rst_dc_wr_rdy", dc_wr_rdy, 0);
        tick(); reset = 1'b0;
        look(); chk("idle_dc_wr_rdy", dc_wr_rdy, 1); chk("idle_ar_valid", mem_ar_valid, 0);
        tick();

        // icache line refill, AR ready after two waiting cycles
        ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1c000040;
        look(); chk("t2_ic_rdy", ic_rd_rdy, 1);
        tick(); ic_rd_req = 0;
        look(); chk("t2_ar_valid", mem_ar_valid, 1); chk("t2_ar_len", mem_ar_len, 3);
        chk("t2_ar_size", mem_ar_size, 2); chk("t2_ar_addr", mem_ar_addr, 32'h1c000040);
        tick();
        look(); chk("t2_ar_hold", mem_ar_valid, 1);
        tick(); mem_ar_ready = 1;
        tick(); mem_ar_ready = 0;
        for (int i = 0; i < 4; i++) begin
            mem_r_valid = 1; mem_r_data = 32'h11 * (i + 1); mem_r_last = (i == 3);
            look();
            chk("t2_ic_ret_data", ic_ret_data, 32'h11 * (i + 1));
            chk("t2_ic_ret_last", ic_ret_last, i == 3);
            chk("t2_dc_ret_valid", dc_ret_valid, 0);
            tick();
        end
        mem_r_valid = 0; mem_r_last = 0;
        look(); chk("t2_back_idle", mem_r_ready, 0);
        tick();

        // Simultaneous requests
        ic_rd_req = 1; ic_rd_type = 3'b010; ic_rd_addr = 32'h3000;
        dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h4000;
        look(); chk("t3_tie1_dc_rdy", dc_rd_rdy, 1); chk("t3_tie1_ic_rdy", ic_rd_rdy, 0);
        tick(); ic_rd_req = 0; dc_rd_req = 0;
        look(); chk("t3_ar_addr", mem_ar_addr, 32'h4000); chk("t3_ar_len", mem_ar_len, 0);
        serve_read(1, 32'hA0);
        ic_rd_req = 1; dc_rd_req = 1;
        look();
`ifdef CACHE_ARB_RR_EN
        chk("t3_tie2_ic_rdy", ic_rd_rdy, 1); chk("t3_tie2_dc_rdy", dc_rd_rdy, 0);
`else
        chk("t3_tie2_ic_rdy", ic_rd_rdy, 0); chk("t3_tie2_dc_rdy", dc_rd_rdy, 1);
`endif
        tick(); ic_rd_req = 0; dc_rd_req = 0;
        serve_read(1, 32'hB0);

        // Line write-back with a same-line dcache read and an unrelated icache read
        dc_wr_req = 1; dc_wr_type = 3'b100; dc_wr_addr = 32'h00001230; dc_wr_wstrb = 4'h0;
        dc_wr_data = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h00001238;
        look(); chk("t4_wr_rdy", dc_wr_rdy, 1); chk("t4_rd_blocked0", dc_rd_rdy, 0);
        tick(); dc_wr_req = 0; ic_rd_req = 1; ic_rd_type = 3'b010; ic_rd_addr = 32'h2000;
        mem_aw_ready = 1;
        look(); chk("t4_rd_blocked1", dc_rd_rdy, 0); chk("t4_ic_rdy", ic_rd_rdy, 1);
        chk("t4_aw_len", mem_aw_len, 3); chk("t4_aw_addr", mem_aw_addr, 32'h1230);
        chk("t4_wr_busy", dc_wr_rdy, 0);
        tick(); ic_rd_req = 0; mem_aw_ready = 0; mem_ar_ready = 1; mem_w_ready = 1;
        for (int i = 0; i < 4; i++) begin
            look();
            chk("t4_w_data", mem_w_data, 32'hD000_0000 + i);
            chk("t4_w_strb", mem_w_strb, 4'hF);
            chk("t4_w_last", mem_w_last, i == 3);
            chk("t4_rd_blocked_w", dc_rd_rdy, 0);
            tick();
            mem_ar_ready = 0;
            mem_r_valid = (i == 0); mem_r_last = (i == 0); mem_r_data = 32'h55;
            if (i == 1) begin
                // the icache single-word read completed during the write burst
                chk("t4_ic_done", mem_r_ready, 0);
            end
        end
        mem_w_ready = 0; mem_r_valid = 0; mem_r_last = 0;
        look(); chk("t4_b_ready", mem_b_ready, 1); chk("t4_rd_blocked_b", dc_rd_rdy, 0);
        tick(); mem_b_valid = 1;
        look(); chk("t4_wr_rdy_b", dc_wr_rdy, 0); chk("t4_rd_blocked_bv", dc_rd_rdy, 0);
        tick(); mem_b_valid = 0;
        look(); chk("t4_wr_rdy_after", dc_wr_rdy, 1); chk("t4_rd_unblocked", dc_rd_rdy, 1);
        tick(); dc_rd_req = 0;
        serve_read(1, 32'hC0);

        // Single-word partial write
        dc_wr_req = 1; dc_wr_type = 3'b010; dc_wr_addr = 32'h100; dc_wr_wstrb = 4'b0011;
        dc_wr_data = {96'd0, 32'h1234_5678};
        look(); chk("t5_wr_rdy", dc_wr_rdy, 1);
        tick(); dc_wr_req = 0; mem_aw_ready = 1;
        look(); chk("t5_aw_len", mem_aw_len, 0); chk("t5_aw_size", mem_aw_size, 2);
        tick(); mem_aw_ready = 0; mem_w_ready = 1;
        look(); chk("t5_w_strb", mem_w_strb, 4'b0011); chk("t5_w_last", mem_w_last, 1);
        chk("t5_w_data", mem_w_data, 32'h1234_5678);
        tick(); mem_w_ready = 0; mem_b_valid = 1;
        look(); chk("t5_b_ready", mem_b_ready, 1);
        tick(); mem_b_valid = 0;
        look(); chk("t5_wr_rdy_after", dc_wr_rdy, 1);
        tick();

        // Reset in the middle of a line refill
        ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1c000080;
        tick(); ic_rd_req = 0; mem_ar_ready = 1;
        tick(); mem_ar_ready = 0; mem_r_valid = 1; mem_r_data = 32'h66; mem_r_last = 0;
        look(); chk("t6_beat0", ic_ret_valid, 1);
        tick(); reset = 1;
        look(); chk("t6_rst_ret_valid", ic_ret_valid, 0); chk("t6_rst_r_ready", mem_r_ready, 0);
        tick(); reset = 0; mem_r_valid = 0;
        ic_rd_req = 1; ic_rd_type = 3'b010; ic_rd_addr = 32'h1c0000c0;
        look(); chk("t6_ic_rdy_after_rst", ic_rd_rdy, 1);
        tick(); ic_rd_req = 0;
        serve_read(1, 32'h77);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
